fp_input_conditioner: RTL and testbench



---
 rtl/fp_input_conditioner.sv | 141 ++++++++++++++
 tb/tb_fp_input_conditioner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_input_conditioner.sv
// -----------------------------------------------------------------------------
// fp_input_conditioner
//
// Cleans up the raw Nexys4 buttons and front-panel switches before they reach
// the front-panel logic. Every input bit is synchronised through two flops.
// Each button is then debounced on its own. The switch word is debounced as a
// whole, so a partially settled word never appears on sw_out. Clean levels are
// delivered together with one-cycle edge pulses.
//
// Ports
//   clock        system clock
//   resetN       asynchronous, active-low reset
//   btn_in       raw buttons {btnr, btnl, btnd, btnu, btnc}, active-high
//   sw_in        raw switches, active-high
//   btn_level    debounced button state
//   btn_press    one-cycle pulse on each debounced 0->1 button transition
//   btn_release  one-cycle pulse on each debounced 1->0 button transition
//   sw_out       debounced switch word
//   sw_change    one-cycle pulse when sw_out updates
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module fp_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NUM_BTN         = 5,
    parameter int NUM_SW          = 13
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic [NUM_SW-1:0]  sw_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_SW-1:0]  sw_out,
    output logic               sw_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter never goes past this value. Reaching it with the input still
    // different from the stable state is what accepts the new level.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] btn_s1_reg, btn_s2_reg;
    logic [NUM_SW-1:0]  sw_s1_reg,  sw_s2_reg;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            btn_s1_reg <= '0;
            btn_s2_reg <= '0;
            sw_s1_reg  <= '0;
            sw_s2_reg  <= '0;
        end else begin
            btn_s1_reg <= btn_in;
            btn_s2_reg <= btn_s1_reg;
            sw_s1_reg  <= sw_in;
            sw_s2_reg  <= sw_s1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-button debounce: one stable state and one counter per button
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [CW-1:0] cnt_reg;
            logic          state_reg;
            logic          press_reg;
            logic          release_reg;

            always_ff @(posedge clock or negedge resetN) begin
                if (!resetN) begin
                    cnt_reg     <= '0;
                    state_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    if (btn_s2_reg[gi] == state_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        // The pulse is registered on the same edge as the new
                        // level, so both are visible in the same cycle.
                        state_reg   <= btn_s2_reg[gi];
                        cnt_reg     <= '0;
                        press_reg   <= btn_s2_reg[gi];
                        release_reg <= ~btn_s2_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end

            assign btn_level[gi]   = state_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Switch-word debounce: one shared counter for the whole vector
    // ------------------------------------------------------------------
    // A bit moving anywhere in the word must restart acceptance. Movement is
    // detected by comparing s1 with s2. s1 is the value s2 will take on the
    // next edge, so this is the same test as "s2 differs from its previous
    // value", seen one cycle earlier. That early view gives the switches the
    // same acceptance latency as the buttons.
    logic [CW-1:0]     sw_cnt_reg;
    logic [NUM_SW-1:0] sw_out_reg;
    logic              sw_change_reg;
    logic              sw_moving;

    assign sw_moving = (sw_s1_reg != sw_s2_reg);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sw_cnt_reg    <= '0;
            sw_out_reg    <= '0;
            sw_change_reg <= 1'b0;
        end else begin
            sw_change_reg <= 1'b0;
            if (sw_moving || (sw_s2_reg == sw_out_reg)) begin
                sw_cnt_reg <= '0;
            end else if (sw_cnt_reg == CNT_LAST) begin
                sw_out_reg    <= sw_s2_reg;
                sw_cnt_reg    <= '0;
                sw_change_reg <= 1'b1;
            end else begin
                sw_cnt_reg <= sw_cnt_reg + CW'(1);
            end
        end
    end

    assign sw_out    = sw_out_reg;
    assign sw_change = sw_change_reg;

endmodule

// File: tb/tb_fp_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_fp_input_conditioner
//
// Directed bench for fp_input_conditioner with DEBOUNCE_CYCLES = 8. Inputs
// change on the falling edge. Outputs are read on the falling edge, so after
// step(n) exactly n rising edges have passed since the last input change.
// With this timing, a new level must appear after 10 rising edges.
// -----------------------------------------------------------------------------
module tb_fp_input_conditioner;

    localparam int DEB = 8;
    localparam int NB  = 5;
    localparam int NS  = 13;

    logic          clock = 1'b0;
    logic          resetN;
    logic [NB-1:0] btn_in;
    logic [NS-1:0] sw_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NS-1:0] sw_out;
    logic          sw_change;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, used to prove that no extra pulses occur.
    int   press_total   = 0;
    int   release_total = 0;
    int   change_total  = 0;
    logic saw_0a5       = 1'b0;

    fp_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_BTN        (NB),
        .NUM_SW         (NS)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .btn_in     (btn_in),
        .sw_in      (sw_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .sw_out     (sw_out),
        .sw_change  (sw_change)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        press_total   = press_total + $countones(btn_press);
        release_total = release_total + $countones(btn_release);
        change_total  = change_total + (sw_change ? 1 : 0);
        if (sw_out == 13'h0A5) saw_0a5 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    int p0, r0, c0;

    initial begin
        // ---------------- reset with everything held high ----------------
        resetN = 1'b0;
        btn_in = 5'b11111;
        sw_in  = 13'h1FFF;
        step(3);
        check("rst_level",   32'(btn_level),   0);
        check("rst_press",   32'(btn_press),   0);
        check("rst_release", 32'(btn_release), 0);
        check("rst_sw_out",  32'(sw_out),      0);
        check("rst_change",  32'(sw_change),   0);
        resetN = 1'b1;
        step(9);
        check("rst_c9_level",  32'(btn_level), 0);
        check("rst_c9_sw_out", 32'(sw_out),    0);
        step(1);
        check("rst_c10_level",  32'(btn_level), 'h1F);
        check("rst_c10_press",  32'(btn_press), 'h1F);
        check("rst_c10_sw_out", 32'(sw_out),    'h1FFF);
        check("rst_c10_change", 32'(sw_change), 1);
        step(1);
        check("rst_c11_press",  32'(btn_press), 0);
        check("rst_c11_change", 32'(sw_change), 0);
        btn_in = '0;
        sw_in  = '0;
        step(10);
        check("rst_drop_release", 32'(btn_release), 'h1F);
        check("rst_drop_sw_out",  32'(sw_out),      0);
        check("rst_drop_change",  32'(sw_change),   1);
        step(2);
        $display("reset scenario done: checks=%0d errors=%0d", checks, errors);

        // ---------------- clean press / release of btnc ----------------
        btn_in = 5'b00001;
        step(9);
        check("btnc_c9_level", 32'(btn_level), 0);
        check("btnc_c9_press", 32'(btn_press), 0);
        step(1);
        check("btnc_c10_level", 32'(btn_level), 1);
        check("btnc_c10_press", 32'(btn_press), 1);
        step(1);
        check("btnc_c11_press", 32'(btn_press), 0);
        p0 = press_total;
        step(6);
        check("btnc_held_no_repulse", 32'(press_total), 32'(p0));
        btn_in = 5'b00000;
        step(9);
        check("btnc_rel_c9_level",   32'(btn_level),   1);
        check("btnc_rel_c9_release", 32'(btn_release), 0);
        step(1);
        check("btnc_rel_c10_level",   32'(btn_level),   0);
        check("btnc_rel_c10_release", 32'(btn_release), 1);
        step(1);
        check("btnc_rel_c11_release", 32'(btn_release), 0);
        step(2);
        $display("clean press scenario done: checks=%0d errors=%0d", checks, errors);

        // ---------------- bouncing btnu ----------------
        p0 = press_total;
        r0 = release_total;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_in[1] = ~btn_in[1];
            step(1);
        end
        check("bounce_level",      32'(btn_level),     0);
        check("bounce_no_press",   32'(press_total),   32'(p0));
        check("bounce_no_release", 32'(release_total), 32'(r0));
        btn_in[1] = 1'b1;
        step(9);
        check("bounce_c9_level", 32'(btn_level), 0);
        step(1);
        check("bounce_c10_press", 32'(btn_press), 'h02);
        check("bounce_c10_level", 32'(btn_level), 'h02);
        step(2);
        check("bounce_single_press", 32'(press_total), 32'(p0 + 1));
        btn_in = '0;
        step(12);
        check("bounce_release_count", 32'(release_total), 32'(r0 + 1));
        $display("bounce scenario done: checks=%0d errors=%0d", checks, errors);

        // ---------------- simultaneous btnl + btnr ----------------
        btn_in = 5'b11000;
        step(9);
        check("simul_c9_press", 32'(btn_press), 0);
        step(1);
        check("simul_c10_press", 32'(btn_press), 'h18);
        check("simul_c10_level", 32'(btn_level), 'h18);
        step(1);
        check("simul_c11_press", 32'(btn_press), 0);
        btn_in = '0;
        step(10);
        check("simul_release", 32'(btn_release), 'h18);
        step(2);
        $display("simultaneous scenario done: checks=%0d errors=%0d", checks, errors);

        // ---------------- switch settling ----------------
        c0      = change_total;
        saw_0a5 = 1'b0;
        sw_in   = 13'h0A5;
        step(5);
        sw_in   = 13'h0A7;
        step(9);
        check("sw_c9_out",    32'(sw_out),    0);
        check("sw_c9_change", 32'(sw_change), 0);
        step(1);
        check("sw_c10_out",    32'(sw_out),    'h0A7);
        check("sw_c10_change", 32'(sw_change), 1);
        step(1);
        check("sw_c11_change", 32'(sw_change), 0);
        step(1);
        check("sw_single_change", 32'(change_total), 32'(c0 + 1));
        check("sw_never_0a5",     32'(saw_0a5),      0);
        sw_in = '0;
        step(12);
        check("sw_back_to_zero", 32'(sw_out), 0);
        $display("switch settling scenario done: checks=%0d errors=%0d", checks, errors);

        // ---------------- reset in the middle of a btnd press ----------------
        p0     = press_total;
        btn_in = 5'b00100;
        step(6);
        check("midrst_pre_level", 32'(btn_level), 0);
        resetN = 1'b0;
        #1;
        check("midrst_in_reset_press", 32'(btn_press), 0);
        step(2);
        check("midrst_no_press", 32'(press_total), 32'(p0));
        resetN = 1'b1;
        step(9);
        check("midrst_c9_level", 32'(btn_level), 0);
        step(1);
        check("midrst_c10_press", 32'(btn_press), 'h04);
        check("midrst_c10_level", 32'(btn_level), 'h04);
        step(1);
        check("midrst_c11_press", 32'(btn_press), 0);
        step(1);
        check("midrst_press_count", 32'(press_total), 32'(p0 + 1));
        $display("reset mid-count scenario done: checks=%0d errors=%0d", checks, errors);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
